// File: rtl/cpu_pkg.sv
// Shared types for the accumulator CPU control path: opcode and phase
// encodings, the bundled strobe struct and the ALU-opcode classifier.
// No ports; imported by cpu_phase_cnt and cpu_seq_ctrl.
package cpu_pkg;

   localparam int OP_W = 3;
   localparam int PH_W = 3;

   typedef enum logic [OP_W-1:0] {
      OP_HLT = 3'b000,
      OP_SKZ = 3'b001,
      OP_ADD = 3'b010,
      OP_AND = 3'b011,
      OP_XOR = 3'b100,
      OP_LDA = 3'b101,
      OP_STO = 3'b110,
      OP_JMP = 3'b111
   } opcode_e;

   typedef enum logic [PH_W-1:0] {
      INST_ADDR  = 3'd0,
      INST_FETCH = 3'd1,
      INST_LOAD  = 3'd2,
      IDLE       = 3'd3,
      OP_ADDR    = 3'd4,
      OP_FETCH   = 3'd5,
      ALU_OP     = 3'd6,
      STORE      = 3'd7
   } phase_e;

   // The nine control strobes driven toward the datapath.
   typedef struct packed {
      logic sel;     // memory address mux: 1 = PC, 0 = IR operand
      logic rd;      // memory read
      logic wr;      // memory write
      logic ld_ir;   // instruction register load
      logic ld_ac;   // accumulator load
      logic inc_pc;  // PC increment
      logic ld_pc;   // PC load (jump)
      logic data_e;  // accumulator onto data bus
      logic halt;    // CPU halted
   } ctrl_t;

   // Opcodes that read an operand from memory and write the accumulator.
   function automatic logic is_aluop(input opcode_e op);
      return (op == OP_ADD) || (op == OP_AND) || (op == OP_XOR) || (op == OP_LDA);
   endfunction

endpackage

// File: rtl/cpu_phase_cnt.sv
// Eight-phase wrapping counter with a sticky halted flag for the sequencer.
// Latency: phase advances on the clk edge where en=1; halted sets on the edge
// leaving OP_ADDR with hlt_op=1. en=0 freezes everything; halted ignores en.
// Ports: clk, rst (async, active-high), en, hlt_op (current opcode is HLT),
//        phase (current phase), halted (parked until reset).
module cpu_phase_cnt
   import cpu_pkg::*;
(
   input  logic   clk,
   input  logic   rst,
   input  logic   en,
   input  logic   hlt_op,
   output phase_e phase,
   output logic   halted
);

   phase_e phase_q, phase_d;
   logic   halted_q, halted_d;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         phase_q  <= INST_ADDR;
         halted_q <= 1'b0;
      end else begin
         phase_q  <= phase_d;
         halted_q <= halted_d;
      end
   end

   // While halted the phase register is left at OP_ADDR, which is why the
   // debug phase output reads 4 for the whole halted period.
   always_comb begin
      phase_d  = phase_q;
      halted_d = halted_q;
      if (!halted_q && en) begin
         if (phase_q == OP_ADDR && hlt_op) begin
            halted_d = 1'b1;
         end else begin
            // 3-bit add wraps STORE back to INST_ADDR.
            phase_d = phase_e'(phase_q + 3'd1);
         end
      end
   end

   assign phase  = phase_q;
   assign halted = halted_q;

endmodule

// File: rtl/cpu_seq_ctrl.sv
// Instruction sequencer for the 5-bit-address accumulator CPU: one
// instruction per eight enabled cycles, strobes decoded from phase/opcode.
// Latency: strobes are a combinational decode of the current phase (no
// extra cycle); en=0 stalls the phase so strobes are held at their level.
// Ports: clk, rst (async, active-high), en, opcode, zero in; sel, rd, wr,
//        ld_ir, ld_ac, inc_pc, ld_pc, data_e, halt, phase (debug) out.
module cpu_seq_ctrl
   import cpu_pkg::*;
#(
   parameter int OP_W = 3
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            en,
   input  logic [OP_W-1:0] opcode,
   input  logic            zero,
   output logic            sel,
   output logic            rd,
   output logic            wr,
   output logic            ld_ir,
   output logic            ld_ac,
   output logic            inc_pc,
   output logic            ld_pc,
   output logic            data_e,
   output logic            halt,
   output logic [2:0]      phase
);

   opcode_e op;
   phase_e  cur_phase;
   logic    halted;
   logic    alu;
   ctrl_t   ctrl;

   // The opcode encoding is fixed at three bits.
   assign op  = opcode_e'(opcode);
   assign alu = is_aluop(op);

   cpu_phase_cnt u_phase_cnt (
      .clk    (clk),
      .rst    (rst),
      .en     (en),
      .hlt_op (op == OP_HLT),
      .phase  (cur_phase),
      .halted (halted)
   );

   // Phases 0-3 fetch the instruction and must not look at opcode, since
   // the IR is only stable once INST_LOAD has completed.
   always_comb begin
      ctrl = '0;
      if (halted) begin
         ctrl.sel  = 1'b1;
         ctrl.halt = 1'b1;
      end else begin
         case (cur_phase)
            INST_ADDR: begin
               ctrl.sel = 1'b1;
            end
            INST_FETCH: begin
               ctrl.sel = 1'b1;
               ctrl.rd  = 1'b1;
            end
            INST_LOAD, IDLE: begin
               ctrl.sel   = 1'b1;
               ctrl.rd    = 1'b1;
               ctrl.ld_ir = 1'b1;
            end
            OP_ADDR: begin
               // PC steps past every instruction here, HLT included, so a
               // restarted CPU resumes after the HLT.
               ctrl.inc_pc = 1'b1;
               ctrl.halt   = (op == OP_HLT);
            end
            OP_FETCH: begin
               ctrl.rd = alu;
            end
            ALU_OP: begin
               ctrl.rd     = alu;
               // zero is live, so a change during a stall shows immediately.
               ctrl.inc_pc = (op == OP_SKZ) && zero;
               ctrl.ld_pc  = (op == OP_JMP);
               ctrl.data_e = (op == OP_STO);
            end
            STORE: begin
               ctrl.rd     = alu;
               ctrl.ld_ac  = alu;
               // JMP raises both PC strobes; the PC block gives load priority.
               ctrl.ld_pc  = (op == OP_JMP);
               ctrl.inc_pc = (op == OP_JMP);
               ctrl.wr     = (op == OP_STO);
               ctrl.data_e = (op == OP_STO);
            end
         endcase
      end
   end

   assign sel    = ctrl.sel;
   assign rd     = ctrl.rd;
   assign wr     = ctrl.wr;
   assign ld_ir  = ctrl.ld_ir;
   assign ld_ac  = ctrl.ld_ac;
   assign inc_pc = ctrl.inc_pc;
   assign ld_pc  = ctrl.ld_pc;
   assign data_e = ctrl.data_e;
   assign halt   = ctrl.halt;
   assign phase  = 3'(cur_phase);

endmodule

// File: tb/tb_cpu_seq_ctrl.sv
// Scoreboard bench for cpu_seq_ctrl: stimulus pushes hand-computed
// {phase, strobes} expectations; a negedge monitor pops and compares.
// Strobe vector order: {sel,rd,wr,ld_ir,ld_ac,inc_pc,ld_pc,data_e,halt}.
module tb_cpu_seq_ctrl;

   localparam logic [2:0] HLT = 3'b000, SKZ = 3'b001, ADD = 3'b010,
                          LDA = 3'b101, STO = 3'b110, JMP = 3'b111;

   // Fetch-phase strobes, identical for every opcode.
   localparam logic [8:0] P0 = 9'b100000000;
   localparam logic [8:0] P1 = 9'b110000000;
   localparam logic [8:0] P2 = 9'b110100000;
   localparam logic [8:0] NONE = 9'b000000000;
   localparam logic [8:0] INC  = 9'b000001000;
   localparam logic [8:0] RD   = 9'b010000000;
   localparam logic [8:0] HALTED = 9'b100000001;

   logic       clk, rst, en, zero;
   logic [2:0] opcode;
   logic       sel, rd, wr, ld_ir, ld_ac, inc_pc, ld_pc, data_e, halt;
   logic [2:0] phase;

   typedef struct {
      int         tag;
      logic [11:0] v;
   } exp_t;

   exp_t sb[$];
   int   pass_cnt = 0;
   int   total_cnt = 0;
   int   step_id = 0;

   cpu_seq_ctrl dut (
      .clk    (clk),
      .rst    (rst),
      .en     (en),
      .opcode (opcode),
      .zero   (zero),
      .sel    (sel),
      .rd     (rd),
      .wr     (wr),
      .ld_ir  (ld_ir),
      .ld_ac  (ld_ac),
      .inc_pc (inc_pc),
      .ld_pc  (ld_pc),
      .data_e (data_e),
      .halt   (halt),
      .phase  (phase)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Monitor: the DUT presents a decode every cycle; compare whenever an
   // expectation is pending.
   always @(negedge clk) begin
      if (sb.size() > 0) begin
         exp_t e;
         logic [11:0] got;
         e   = sb.pop_front();
         got = {phase, sel, rd, wr, ld_ir, ld_ac, inc_pc, ld_pc, data_e, halt};
         total_cnt++;
         if (got !== e.v)
            $display("FAIL step%0d: got phase=%0d strobes=%b, want phase=%0d strobes=%b",
                     e.tag, got[11:9], got[8:0], e.v[11:9], e.v[8:0]);
         else
            pass_cnt++;
      end
   end

   task automatic push(input logic [2:0] ph, input logic [8:0] c);
      exp_t e;
      e.tag = step_id;
      e.v   = {ph, c};
      sb.push_back(e);
      step_id++;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic step(input logic e_in, input logic [2:0] ph, input logic [8:0] c);
      en = e_in;
      push(ph, c);
      tick();
   endtask

   // One full instruction from phase 0; the opcode is scrambled during the
   // fetch phases to show they do not depend on it.
   task automatic run_instr(input logic [2:0] op, input logic z,
                            input logic [8:0] p4, input logic [8:0] p5,
                            input logic [8:0] p6, input logic [8:0] p7);
      logic [8:0] tab [8];
      tab = '{P0, P1, P2, P2, p4, p5, p6, p7};
      zero = z;
      for (int i = 0; i < 8; i++) begin
         opcode = (i < 4) ? ~op : op;
         step(1'b1, 3'(i), tab[i]);
      end
   endtask

   task automatic fetch_phases(input logic [2:0] op);
      opcode = op;
      step(1'b1, 3'd0, P0);
      step(1'b1, 3'd1, P1);
      step(1'b1, 3'd2, P2);
      step(1'b1, 3'd3, P2);
   endtask

   initial begin
      rst = 1'b1; en = 1'b1; opcode = LDA; zero = 1'b0;
      tick();
      push(3'd0, P0);            // reset state with en=1
      tick();
      rst = 1'b0;

      run_instr(LDA, 1'b0, INC, RD, RD, 9'b010010000);
      run_instr(STO, 1'b0, INC, NONE, 9'b000000010, 9'b001000010);
      run_instr(SKZ, 1'b1, INC, NONE, INC, NONE);
      run_instr(SKZ, 1'b0, INC, NONE, NONE, NONE);
      run_instr(JMP, 1'b0, INC, NONE, 9'b000000100, 9'b000001100);

      // ADD stalled three cycles in ALU_OP.
      fetch_phases(ADD);
      step(1'b1, 3'd4, INC);
      step(1'b1, 3'd5, RD);
      step(1'b0, 3'd6, RD);
      step(1'b0, 3'd6, RD);
      step(1'b0, 3'd6, RD);
      step(1'b1, 3'd6, RD);
      step(1'b1, 3'd7, 9'b010010000);

      // SKZ stalled in ALU_OP while zero toggles.
      zero = 1'b0;
      fetch_phases(SKZ);
      step(1'b1, 3'd4, INC);
      step(1'b1, 3'd5, NONE);
      zero = 1'b0; step(1'b0, 3'd6, NONE);
      zero = 1'b1; step(1'b0, 3'd6, INC);
      zero = 1'b0; step(1'b0, 3'd6, NONE);
      zero = 1'b1; step(1'b1, 3'd6, INC);
      step(1'b1, 3'd7, NONE);

      // Reset asserted mid-OP_FETCH: must take effect before the cycle ends.
      fetch_phases(ADD);
      step(1'b1, 3'd4, INC);
      en = 1'b1;
      rst = 1'b1;
      push(3'd0, P0);
      tick();
      push(3'd0, P0);
      tick();
      rst = 1'b0;

      // HLT: parked at phase 4 regardless of en/opcode until reset.
      for (int i = 0; i < 4; i++) begin
         opcode = JMP;
         step(1'b1, 3'(i), (i == 0) ? P0 : (i == 1) ? P1 : P2);
      end
      opcode = HLT;
      step(1'b1, 3'd4, 9'b000001001);
      for (int i = 0; i < 22; i++) begin
         opcode = 3'($urandom_range(0, 7));
         zero   = 1'($urandom_range(0, 1));
         step(1'($urandom_range(0, 1)), 3'd4, HALTED);
      end
      rst = 1'b1;
      push(3'd0, P0);
      tick();
      rst = 1'b0;
      opcode = LDA;
      step(1'b1, 3'd0, P0);
      step(1'b1, 3'd1, P1);

      tick();
      tick();
      if (sb.size() != 0) begin
         total_cnt++;
         $display("FAIL drain: %0d expectations left unchecked, want 0", sb.size());
      end
      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, checks=%0d", total_cnt);
      $fatal(1);
   end

endmodule
